// File: rtl/mem_wb_stage.sv
// mem_wb_stage: final pipeline register between memory access and writeback.
// It formats load data, selects the writeback value, flags misaligned loads,
// and counts retired instructions.
module mem_wb_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  input  logic            reg_write_i,
  input  logic [4:0]      rd_addr_i,
  input  logic [1:0]      wb_sel_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] load_data_i,
  input  logic [2:0]      load_funct3_i,
  input  logic [2:0]      addr_lo_i,
  output logic            valid_wb_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            reg_write_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            misaligned_o,
  output logic [XLEN-1:0] instret_o
);

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Writeback source encodings
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  logic            capture;
  logic [XLEN-1:0] loadShifted;
  logic [XLEN-1:0] loadValue;
  logic            loadMisaligned;

  logic            validWb_d,    validWb_q;
  logic            regWrite_d,   regWrite_q;
  logic            misaligned_d, misaligned_q;
  logic [XLEN-1:0] pc_d,         pc_q;
  logic [31:0]     instr_d,      instr_q;
  logic [4:0]      rdAddr_d,     rdAddr_q;
  logic [XLEN-1:0] rdData_d,     rdData_q;
  logic [XLEN-1:0] instret_d,    instret_q;

  // An instruction transfers only when presented, not stalled and not flushed
  always_comb begin
    capture = valid_i & ~stall_i & ~flush_i;
  end

  // Align the addressed bytes to bit 0 and extend them according to the load type
  always_comb begin
    loadShifted = load_data_i >> {addr_lo_i, 3'b000};
    case (load_funct3_i)
      F3_LB:   loadValue = {{(XLEN-8){loadShifted[7]}},   loadShifted[7:0]};
      F3_LH:   loadValue = {{(XLEN-16){loadShifted[15]}}, loadShifted[15:0]};
      F3_LW:   loadValue = {{(XLEN-32){loadShifted[31]}}, loadShifted[31:0]};
      F3_LD:   loadValue = loadShifted;
      F3_LBU:  loadValue = {{(XLEN-8){1'b0}},  loadShifted[7:0]};
      F3_LHU:  loadValue = {{(XLEN-16){1'b0}}, loadShifted[15:0]};
      F3_LWU:  loadValue = {{(XLEN-32){1'b0}}, loadShifted[31:0]};
      default: loadValue = '0;
    endcase
  end

  // A load is misaligned when its offset is not a multiple of its access size
  always_comb begin
    loadMisaligned = 1'b0;
    if (wb_sel_i == WB_LOAD) begin
      case (load_funct3_i)
        F3_LH, F3_LHU: loadMisaligned = addr_lo_i[0];
        F3_LW, F3_LWU: loadMisaligned = |addr_lo_i[1:0];
        F3_LD:         loadMisaligned = |addr_lo_i;
        default:       loadMisaligned = 1'b0;
      endcase
    end
  end

  // Next-state for the stage register; payload holds its value on a bubble
  always_comb begin
    validWb_d    = capture;
    misaligned_d = capture & loadMisaligned;
    regWrite_d   = capture & reg_write_i & (rd_addr_i != 5'd0) & ~loadMisaligned;
    pc_d         = pc_q;
    instr_d      = instr_q;
    rdAddr_d     = rdAddr_q;
    rdData_d     = rdData_q;
    if (capture) begin
      pc_d     = pc_i;
      instr_d  = instr_i;
      rdAddr_d = rd_addr_i;
      case (wb_sel_i)
        WB_ALU:  rdData_d = alu_result_i;
        WB_LOAD: rdData_d = loadValue;
        WB_PC4:  rdData_d = pc_i + XLEN'(4);
        default: rdData_d = '0;
      endcase
    end
  end

  // Retirement counter advances on each properly retiring instruction and wraps silently
  always_comb begin
    instret_d = instret_q;
    if (validWb_q && !misaligned_q) begin
      instret_d = instret_q + XLEN'(1);
    end
  end

  // Stage register, cleared asynchronously so a held reset discards any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validWb_q    <= 1'b0;
      regWrite_q   <= 1'b0;
      misaligned_q <= 1'b0;
      pc_q         <= '0;
      instr_q      <= '0;
      rdAddr_q     <= '0;
      rdData_q     <= '0;
    end else begin
      validWb_q    <= validWb_d;
      regWrite_q   <= regWrite_d;
      misaligned_q <= misaligned_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      rdAddr_q     <= rdAddr_d;
      rdData_q     <= rdData_d;
    end
  end

  // Retired-instruction counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign valid_wb_o   = validWb_q;
  assign reg_write_o  = regWrite_q;
  assign misaligned_o = misaligned_q;
  assign pc_o         = pc_q;
  assign instr_o      = instr_q;
  assign rd_addr_o    = rdAddr_q;
  assign rd_data_o    = rdData_q;
  assign instret_o    = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed and randomized checks of mem_wb_stage against a
// behavioural model of writeback formatting, retirement and reset behaviour.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        stall_i;
  logic        flush_i;
  logic [63:0] pc_i;
  logic [31:0] instr_i;
  logic        reg_write_i;
  logic [4:0]  rd_addr_i;
  logic [1:0]  wb_sel_i;
  logic [63:0] alu_result_i;
  logic [63:0] load_data_i;
  logic [2:0]  load_funct3_i;
  logic [2:0]  addr_lo_i;
  logic        valid_wb_o;
  logic [63:0] pc_o;
  logic [31:0] instr_o;
  logic        reg_write_o;
  logic [4:0]  rd_addr_o;
  logic [63:0] rd_data_o;
  logic        misaligned_o;
  logic [63:0] instret_o;

  int numVectors = 0;
  int numMiscompares = 0;

  logic        expValid;
  logic        expRegWrite;
  logic        expMisaligned;
  logic [63:0] expPc;
  logic [31:0] expInstr;
  logic [4:0]  expRdAddr;
  logic [63:0] expRdData;
  logic [63:0] expInstret;
  logic [63:0] savedInstret;

  mem_wb_stage #(.XLEN(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_i       (valid_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .pc_i          (pc_i),
    .instr_i       (instr_i),
    .reg_write_i   (reg_write_i),
    .rd_addr_i     (rd_addr_i),
    .wb_sel_i      (wb_sel_i),
    .alu_result_i  (alu_result_i),
    .load_data_i   (load_data_i),
    .load_funct3_i (load_funct3_i),
    .addr_lo_i     (addr_lo_i),
    .valid_wb_o    (valid_wb_o),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .reg_write_o   (reg_write_o),
    .rd_addr_o     (rd_addr_o),
    .rd_data_o     (rd_data_o),
    .misaligned_o  (misaligned_o),
    .instret_o     (instret_o)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any difference
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    numVectors++;
    if (observed !== expected) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Access size in bytes of a load type
  function automatic int accessBytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      default:    return 8;
    endcase
  endfunction

  // Reference load result: pick the bytes at the offset, then mask and extend arithmetically
  function automatic logic [63:0] refLoad(input logic [63:0] data, input logic [2:0] f3, input logic [2:0] addr);
    logic [63:0] s;
    logic [63:0] mask;
    logic [63:0] v;
    int          n;
    if (f3 == 3'd7) return 64'd0;
    s = data >> (8 * int'(addr));
    n = accessBytes(f3);
    if (n == 8) return s;
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = s & mask;
    if (f3 < 3'd4 && v > (mask >> 1)) v = v | ~mask;
    return v;
  endfunction

  function automatic bit refMisaligned(input logic [1:0] sel, input logic [2:0] f3, input logic [2:0] addr);
    if (sel != 2'b01 || f3 == 3'd7) return 1'b0;
    return (int'(addr) % accessBytes(f3)) != 0;
  endfunction

  function automatic logic [63:0] refResult(input logic [1:0] sel, input logic [63:0] alu, input logic [63:0] pc,
                                            input logic [63:0] data, input logic [2:0] f3, input logic [2:0] addr);
    case (sel)
      2'b00:   return alu;
      2'b01:   return refLoad(data, f3, addr);
      2'b10:   return pc + 64'd4;
      default: return 64'd0;
    endcase
  endfunction

  task automatic modelReset();
    expValid      = 1'b0;
    expRegWrite   = 1'b0;
    expMisaligned = 1'b0;
    expPc         = '0;
    expInstr      = '0;
    expRdAddr     = '0;
    expRdData     = '0;
    expInstret    = '0;
  endtask

  // One rising edge of the reference model, using the inputs the bench is driving
  task automatic modelStep();
    bit mis;
    if (!rst_n) begin
      modelReset();
      return;
    end
    if (expValid && !expMisaligned) expInstret = expInstret + 64'd1;
    if (valid_i && !stall_i && !flush_i) begin
      mis           = refMisaligned(wb_sel_i, load_funct3_i, addr_lo_i);
      expValid      = 1'b1;
      expMisaligned = mis;
      expRegWrite   = reg_write_i && (rd_addr_i != 5'd0) && !mis;
      expPc         = pc_i;
      expInstr      = instr_i;
      expRdAddr     = rd_addr_i;
      expRdData     = refResult(wb_sel_i, alu_result_i, pc_i, load_data_i, load_funct3_i, addr_lo_i);
    end else begin
      expValid      = 1'b0;
      expRegWrite   = 1'b0;
      expMisaligned = 1'b0;
    end
  endtask

  task automatic checkAll();
    checkOutput("valid_wb", valid_wb_o, expValid);
    checkOutput("reg_write", reg_write_o, expRegWrite);
    checkOutput("misaligned", misaligned_o, expMisaligned);
    checkOutput("pc", pc_o, expPc);
    checkOutput("instr", instr_o, expInstr);
    checkOutput("rd_addr", rd_addr_o, expRdAddr);
    checkOutput("rd_data", rd_data_o, expRdData);
    checkOutput("instret", instret_o, expInstret);
  endtask

  task automatic applyStimulus(input logic v, input logic s, input logic f, input logic [63:0] pc,
                               input logic [31:0] ins, input logic rw, input logic [4:0] rd,
                               input logic [1:0] sel, input logic [63:0] alu, input logic [63:0] data,
                               input logic [2:0] f3, input logic [2:0] addr);
    valid_i       = v;
    stall_i       = s;
    flush_i       = f;
    pc_i          = pc;
    instr_i       = ins;
    reg_write_i   = rw;
    rd_addr_i     = rd;
    wb_sel_i      = sel;
    alu_result_i  = alu;
    load_data_i   = data;
    load_funct3_i = f3;
    addr_lo_i     = addr;
  endtask

  task automatic applyBubble();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 5'd0, 2'b00, 64'h0, 64'h0, 3'd0, 3'd0);
  endtask

  // Advance one clock and compare every output against the model away from the edge
  task automatic cycleAndCheck();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    rst_n = 1'b0;
    applyBubble();
    modelReset();

    // Reset state
    @(negedge clk);
    checkAll();
    rst_n = 1'b1;

    // ALU write
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h8000_0000, 32'h0000_02b3, 1'b1, 5'd5, 2'b00,
                  64'h1234, 64'h0, 3'd0, 3'd0);
    cycleAndCheck();
    checkOutput("alu_valid", valid_wb_o, 64'd1);
    checkOutput("alu_regwrite", reg_write_o, 64'd1);
    checkOutput("alu_data", rd_data_o, 64'h1234);
    checkOutput("alu_pc", pc_o, 64'h8000_0000);
    applyBubble();
    cycleAndCheck();
    checkOutput("alu_instret", instret_o, 64'd1);

    // Load extension
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h8000_0004, 32'h0030_0383, 1'b1, 5'd7, 2'b01,
                  64'h0, 64'h0000_0000_80FF_0000, 3'd0, 3'd3);
    cycleAndCheck();
    checkOutput("lb_data", rd_data_o, 64'hFFFF_FFFF_FFFF_FF80);
    load_funct3_i = 3'd4;
    cycleAndCheck();
    checkOutput("lbu_data", rd_data_o, 64'h80);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h8000_000C, 32'h0040_6383, 1'b1, 5'd7, 2'b01,
                  64'h0, 64'hDEAD_BEEF_0000_0000, 3'd6, 3'd4);
    cycleAndCheck();
    checkOutput("lwu_data", rd_data_o, 64'h0000_0000_DEAD_BEEF);

    // Stall then release, then stall plus flush
    applyBubble();
    cycleAndCheck();
    savedInstret = instret_o;
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h8000_0010, 32'h0013_0313, 1'b1, 5'd6, 2'b10,
                  64'h0, 64'h0, 3'd0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      cycleAndCheck();
      checkOutput("stall_bubble", valid_wb_o, 64'd0);
      checkOutput("stall_instret", instret_o, savedInstret);
    end
    stall_i = 1'b0;
    cycleAndCheck();
    checkOutput("stall_release", valid_wb_o, 64'd1);
    checkOutput("pc4_data", rd_data_o, 64'h8000_0014);
    valid_i = 1'b0;
    cycleAndCheck();
    checkOutput("no_repeat", valid_wb_o, 64'd0);
    savedInstret = instret_o;
    valid_i = 1'b1;
    stall_i = 1'b1;
    flush_i = 1'b1;
    cycleAndCheck();
    checkOutput("flush_stall", valid_wb_o, 64'd0);
    checkOutput("flush_instret", instret_o, savedInstret);

    // Misaligned word load and x0 destination
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h8000_0020, 32'h0020_2383, 1'b1, 5'd9, 2'b01,
                  64'h0, 64'h1122_3344_5566_7788, 3'd2, 3'd2);
    cycleAndCheck();
    checkOutput("mis_flag", misaligned_o, 64'd1);
    checkOutput("mis_regwrite", reg_write_o, 64'd0);
    savedInstret = instret_o;
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h8000_0024, 32'h0000_0013, 1'b1, 5'd0, 2'b00,
                  64'hABCD, 64'h0, 3'd0, 3'd0);
    cycleAndCheck();
    checkOutput("mis_instret", instret_o, savedInstret);
    checkOutput("x0_regwrite", reg_write_o, 64'd0);
    checkOutput("x0_valid", valid_wb_o, 64'd1);

    // Counter wrap: preset the counter to all ones while a retirement is pending
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h8000_0028, 32'h0010_0093, 1'b1, 5'd1, 2'b00,
                  64'h55, 64'h0, 3'd0, 3'd0);
    cycleAndCheck();
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    expInstret = 64'hFFFF_FFFF_FFFF_FFFF;
    checkOutput("wrap_preset", instret_o, expInstret);
    applyBubble();
    cycleAndCheck();
    checkOutput("wrap_zero", instret_o, 64'd0);

    // Asynchronous reset between edges, with an instruction presented during reset
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h8000_0030, 32'h0020_0113, 1'b1, 5'd2, 2'b10,
                  64'h0, 64'h0, 3'd0, 3'd0);
    cycleAndCheck();
    cycleAndCheck();
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("arst_valid", valid_wb_o, 64'd0);
    checkOutput("arst_regwrite", reg_write_o, 64'd0);
    checkOutput("arst_misaligned", misaligned_o, 64'd0);
    checkOutput("arst_pc", pc_o, 64'd0);
    checkOutput("arst_instr", instr_o, 64'd0);
    checkOutput("arst_rd_addr", rd_addr_o, 64'd0);
    checkOutput("arst_rd_data", rd_data_o, 64'd0);
    checkOutput("arst_instret", instret_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyBubble();
    cycleAndCheck();
    checkOutput("arst_discard", valid_wb_o, 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h8000_0040, 32'h0030_0193, 1'b1, 5'd3, 2'b00,
                  64'h77, 64'h0, 3'd0, 3'd0);
    cycleAndCheck();
    checkOutput("first_capture", valid_wb_o, 64'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) < 8), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                    {$urandom, $urandom}, $urandom, $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      cycleAndCheck();
    end

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, the datapath width; only 64 is supported.
REQ-002 SHALL have ports, one per line:
  clk  in  1  core clock, rising edge.
  rst_n  in  1  reset, asynchronous and active-low.
  valid_i  in  1  the MEM stage presents an instruction this cycle.
  stall_i  in  1  MEM stalled; no instruction transfers this cycle.
  flush_i  in  1  kill the incoming instruction.
  pc_i  in  64  instruction PC.
  instr_i  in  32  raw machine code.
  reg_write_i  in  1  instruction writes rd.
  rd_addr_i  in  5  destination register.
  wb_sel_i  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 reserved.
  alu_result_i  in  64  ALU result.
  load_data_i  in  64  raw 8-byte-aligned doubleword read from memory.
  load_funct3_i  in  3  load type: LB, LH, LW, LD, LBU, LHU, LWU, 111 reserved.
  addr_lo_i  in  3  byte offset of the load address within the doubleword.
  valid_wb_o  out  1  one instruction retires this cycle.
  pc_o  out  64  PC of the retiring instruction.
  instr_o  out  32  raw instruction of the retiring instruction.
  reg_write_o  out  1  register file write enable.
  rd_addr_o  out  5  register file write address.
  rd_data_o  out  64  register file write data.
  misaligned_o  out  1  the retiring load was misaligned.
  instret_o  out  64  count of retired instructions.

Function
REQ-003 SHALL register all outputs except instret_o: 1-cycle latency from an input cycle to the matching output cycle.
REQ-004 SHALL compute rd_data_o before the output register, so rd_data_o has no combinational path from the inputs.
REQ-005 Transfer rule: valid_i=1, stall_i=0 and flush_i=0 at a rising edge captures the instruction; next cycle valid_wb_o=1.
REQ-006 Bubble rule: any other input combination at a rising edge loads valid_wb_o=0, reg_write_o=0 and misaligned_o=0.
REQ-007 flush_i SHALL override stall_i and valid_i; stall_i and flush_i both high gives a bubble.
REQ-008 During a bubble, pc_o, instr_o, rd_addr_o and rd_data_o SHALL hold their previous values.
REQ-009 valid_wb_o SHALL be high for exactly one cycle per captured instruction, with no repeat across stalls.
REQ-010 Result selection:
  - wb_sel 00: rd_data = alu_result_i.
  - wb_sel 10: rd_data = pc_i + 4, modulo 2^64.
  - wb_sel 11: rd_data = 0.
  - wb_sel 01: load extraction per REQ-011.
REQ-011 Load extraction: shift load_data_i right by 8*addr_lo_i, then:
  - LB: sign-extend bits 7:0; LBU: zero-extend bits 7:0.
  - LH: sign-extend bits 15:0; LHU: zero-extend bits 15:0.
  - LW: sign-extend bits 31:0; LWU: zero-extend bits 31:0.
  - LD: take all 64 bits.
  - funct3 111: result is 0.
REQ-012 Misaligned load (wb_sel 01 only):
  - H types with addr_lo[0]!=0.
  - W types with addr_lo[1:0]!=0.
  - LD with addr_lo!=0.
  - Byte loads are never misaligned.
REQ-013 A captured misaligned load SHALL set misaligned_o=1 with valid_wb_o=1 and force reg_write_o=0.
REQ-014 reg_write_o SHALL be 1 only when all hold: the instruction is captured, reg_write_i=1, rd_addr_i!=0 and the load is not misaligned.
REQ-015 rd_addr_o SHALL carry rd_addr_i unchanged, including x0.
REQ-016 instret_o SHALL be a 64-bit register that increments by 1 on each rising edge where valid_wb_o=1 and misaligned_o=0.
REQ-017 instret_o SHALL wrap from 2^64-1 to 0 with no flag.
REQ-018 instret_o SHALL be unaffected by stall_i and flush_i.

Reset
REQ-019 While rst_n=0, all outputs SHALL be 0, applied asynchronously and independent of clk.
REQ-020 Reset asserted mid-instruction SHALL discard that instruction: no valid_wb_o pulse after rst_n rises.
REQ-021 The first capture SHALL occur at the first rising edge with rst_n=1.

Verification
REQ-022 ALU write: pc_i=0x80000000, rd=5, wb_sel 00, alu=0x1234 -> next cycle valid_wb_o=1, reg_write_o=1, rd_data_o=0x1234, pc_o=0x80000000; instret_o becomes 1.
REQ-023 Load extension:
  - LB, addr_lo=3, load_data=0x00000000_80FF0000 -> rd_data_o=0xFFFFFFFFFFFFFF80.
  - LBU, same inputs -> rd_data_o=0x80.
  - LWU, addr_lo=4, load_data=0xDEADBEEF_00000000 -> rd_data_o=0x00000000DEADBEEF.
REQ-024 Stall/flush: valid_i=1 with stall_i=1 for 3 cycles, then released -> valid_wb_o low for 3 cycles, then exactly one pulse; flush_i with stall_i -> no pulse; instret_o unchanged during the bubbles.
REQ-025 Misaligned/x0:
  - LW, addr_lo=2 -> misaligned_o=1, reg_write_o=0, instret_o not incremented.
  - reg_write_i=1 with rd=0 -> reg_write_o=0, valid_wb_o=1.
REQ-026 Wrap/reset:
  - Force instret_o to 2^64-1, then retire one -> instret_o=0.
  - Pull rst_n low between edges -> all outputs 0 immediately, with no clock edge.
